serial_mag_cmp_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit unsigned operands by stepping a 2-bit greater-than / equality slice MSB-first, one slice per clock.
- Sits beside the ALU as a low-area magnitude comparator with a start/done handshake.
- Latches operands on start and returns a one-hot agtb/aeqb/altb result with a done pulse.

---
 rtl/serial_mag_cmp_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_mag_cmp_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_cmp_ctrl.sv
// serial_mag_cmp_ctrl: low-area unsigned magnitude comparator.
// Steps a 2-bit greater-than/equal slice over the latched operands, MSB
// first, one slice per clock, and returns a one-hot agtb/aeqb/altb result
// with a single-cycle done pulse.
//
// WIDTH must be even and at least 2; the slice count is WIDTH/2.
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, the first unequal slice ends
//   the compare. When undefined, every compare takes WIDTH/2 RUN cycles.
//   The results are the same in both builds; only the latency differs.
module serial_mag_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb
);

  localparam int K  = WIDTH / 2;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;

  logic [1:0]       sa;
  logic [1:0]       sb;
  logic             slice_gt;
  logic             slice_eq;
  logic             slice_lt;
  logic             accept;
  logic             last_slice;
  logic             leave_run;

  // Current slice is always the top two bits of the shift registers.
  assign sa = sh_a[WIDTH-1 -: 2];
  assign sb = sh_b[WIDTH-1 -: 2];

  assign slice_gt = (sa[0] & ~sb[1] & ~sb[0]) |
                    (sa[1] & ~sb[1]) |
                    (sa[1] & sa[0] & ~sb[0]);
  assign slice_eq = (sa == sb);
  assign slice_lt = ~slice_gt & ~slice_eq;

  // A start is honoured whenever no compare is in flight, including the DONE
  // cycle, so back-to-back compares need no idle gap.
  assign accept     = start && (state != RUN);
  assign last_slice = (cnt == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // The first differing slice settles the answer, so stop right there.
  assign leave_run = last_slice || (!decided && !slice_eq);
`else
  // Constant latency: always walk every slice.
  assign leave_run = last_slice;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: give every combinational output a default before any branch so
    // that no path leaves it unassigned and a latch gets inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (leave_run) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifting, slice counting and result capture.
  always_ff @(posedge clk) begin
    // NOTE: every register here is updated with <= so all of them see the
    // values from before this edge, regardless of statement order.
    if (reset) begin
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      agtb    <= 1'b0;
      aeqb    <= 1'b0;
      altb    <= 1'b0;
    end else if (accept) begin
      sh_a    <= a;
      sh_b    <= b;
      cnt     <= CW'(K - 1);
      decided <= 1'b0;
      agtb    <= 1'b0;
      aeqb    <= 1'b0;
      altb    <= 1'b0;
    end else if (state == RUN) begin
      sh_a <= sh_a << 2;
      sh_b <= sh_b << 2;
      cnt  <= cnt - CW'(1);
      // Only the most significant difference decides; later slices are
      // ignored once decided is set.
      if (!decided && !slice_eq) begin
        agtb    <= slice_gt;
        altb    <= slice_lt;
        decided <= 1'b1;
      end
      // Equal only if the final slice matches and nothing differed before.
      if (leave_run && !decided && slice_eq) begin
        aeqb <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Testbench for serial_mag_cmp_ctrl. Three instances (WIDTH 8, 2, 16) run
// concurrently: directed vectors on WIDTH=8, random pairs on WIDTH=2 and 16.
// Stimulus pushes the expected result and done cycle into a per-instance
// queue; a monitor per instance pops and compares on every done pulse.
module tb_serial_mag_cmp_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0] res;   // {agtb, aeqb, altb}
    int         cyc;   // cycle in which done must be seen
  } exp_t;

  logic clk;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // WIDTH=8 instance
  logic       rst8, st8, busy8, done8, gt8, eq8, lt8;
  logic [7:0] a8, b8;
  // WIDTH=2 instance
  logic       rst2, st2, busy2, done2, gt2, eq2, lt2;
  logic [1:0] a2, b2;
  // WIDTH=16 instance
  logic        rst16, st16, busy16, done16, gt16, eq16, lt16;
  logic [15:0] a16, b16;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q16[$];
  exp_t m8, m2, m16;

  serial_mag_cmp_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst8), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .agtb(gt8), .aeqb(eq8), .altb(lt8)
  );

  serial_mag_cmp_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(rst2), .start(st2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .agtb(gt2), .aeqb(eq2), .altb(lt2)
  );

  serial_mag_cmp_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(rst16), .start(st16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .agtb(gt16), .aeqb(eq16), .altb(lt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number; inputs driven after edge p belong to cycle p.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural reference: plain >, ==, < plus the latency of this build.
  function automatic exp_t model(int w, logic [15:0] av, logic [15:0] bv, int c0);
    exp_t e;
    int   k = w / 2;
    int   lat = k + 1;
    bit   found = 1'b0;
    if (EARLY) begin
      for (int i = 0; i < k; i++) begin
        if (!found && (((av >> (w - 2 - 2 * i)) & 16'h3) !=
                       ((bv >> (w - 2 - 2 * i)) & 16'h3))) begin
          found = 1'b1;
          lat   = i + 2;
        end
      end
    end
    e.res = (av > bv) ? 3'b100 : ((av == bv) ? 3'b010 : 3'b001);
    e.cyc = c0 + lat;
    return e;
  endfunction

  // Directed start on the WIDTH=8 instance with a hand-computed answer.
  task automatic issue8(logic [7:0] av, logic [7:0] bv, logic [2:0] res,
                        int lat, bit push);
    exp_t e;
    e.res = res;
    e.cyc = cyc + lat;
    a8  = av;
    b8  = bv;
    st8 = 1'b1;
    if (push) q8.push_back(e);
    step(1);
    st8 = 1'b0;
  endtask

  task automatic directed8();
    int c0;
    int l4;
    int lf;
    int bc;
    // Equal operands: busy in cycles 1..4, done with aeqb in cycle 5.
    issue8(8'hA5, 8'hA5, 3'b010, 5, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check("w8 busy during run", busy8, 1);
      step(1);
    end
    check("w8 busy clear in done cycle", busy8, 0);
    check("w8 done in cycle 5", done8, 1);
    step(2);

    // Difference in the top slice.
    issue8(8'h80, 8'h7F, 3'b100, EARLY ? 2 : 5, 1'b1);
    step(EARLY ? 2 : 5);
    // Difference only in the last slice: latency 5 in both builds.
    issue8(8'h01, 8'h02, 3'b001, 5, 1'b1);
    step(5);

    // Start while busy is ignored, then a start in the DONE cycle is taken.
    l4 = EARLY ? 3 : 5;
    lf = EARLY ? 2 : 5;
    bc = EARLY ? 1 : 2;
    c0 = cyc;
    issue8(8'h10, 8'h20, 3'b001, l4, 1'b1);
    step(bc - 1);
    a8  = 8'h20;
    b8  = 8'h10;
    st8 = 1'b1;
    check("w8 busy when second start pulsed", busy8, 1);
    step(1);
    st8 = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;
    step(c0 + l4 - cyc);
    check("w8 done before back-to-back start", done8, 1);
    issue8(8'hFF, 8'h00, 3'b100, lf, 1'b1);
    check("w8 results cleared by new start", {gt8, eq8, lt8}, 0);
    check("w8 busy after back-to-back start", busy8, 1);
    step(lf);
    step(2);

    // Reset in cycle 3 of a run: all outputs low and no done afterwards.
    issue8(8'hC3, 8'hC3, 3'b010, 5, 1'b0);
    step(2);
    rst8 = 1'b1;
    step(1);
    check("w8 outputs after mid-run reset", {busy8, done8, gt8, eq8, lt8}, 0);
    rst8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (k % 4 == 0) check("w8 idle after reset", {busy8, done8}, 0);
    end
  endtask

  task automatic run2(int n);
    exp_t       e;
    logic [1:0] av, bv;
    for (int i = 0; i < n; i++) begin
      av = 2'($urandom);
      bv = (i % 5 == 0) ? av : 2'($urandom);
      e  = model(2, 16'(av), 16'(bv), cyc);
      a2 = av;
      b2 = bv;
      st2 = 1'b1;
      q2.push_back(e);
      step(1);
      st2 = 1'b0;
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      step(e.cyc - cyc);
      if ($urandom_range(1) == 1) step(1);
    end
  endtask

  task automatic run16(int n);
    exp_t        e;
    logic [15:0] av, bv;
    for (int i = 0; i < n; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      if (i % 6 == 0) bv = av;
      else if (i % 6 == 1) bv = av ^ (16'h1 << $urandom_range(15));
      e   = model(16, av, bv, cyc);
      a16 = av;
      b16 = bv;
      st16 = 1'b1;
      q16.push_back(e);
      step(1);
      st16 = 1'b0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      step(e.cyc - cyc);
      if ($urandom_range(1) == 1) step(1);
    end
  endtask

  // Monitors: compare on every done pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (done8) begin
      check("w8 done was expected", int'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        m8 = q8.pop_front();
        check("w8 result", {gt8, eq8, lt8}, m8.res);
        check("w8 done cycle", cyc, m8.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      check("w2 done was expected", int'(q2.size() > 0), 1);
      check("w2 one-hot", $countones({gt2, eq2, lt2}), 1);
      if (q2.size() > 0) begin
        m2 = q2.pop_front();
        check("w2 result", {gt2, eq2, lt2}, m2.res);
        check("w2 done cycle", cyc, m2.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      check("w16 done was expected", int'(q16.size() > 0), 1);
      check("w16 one-hot", $countones({gt16, eq16, lt16}), 1);
      if (q16.size() > 0) begin
        m16 = q16.pop_front();
        check("w16 result", {gt16, eq16, lt16}, m16.res);
        check("w16 done cycle", cyc, m16.cyc);
      end
    end
  end

  initial begin
    rst8 = 1'b1;  st8 = 1'b0;  a8 = '0;  b8 = '0;
    rst2 = 1'b1;  st2 = 1'b0;  a2 = '0;  b2 = '0;
    rst16 = 1'b1; st16 = 1'b0; a16 = '0; b16 = '0;
    step(2);
    check("w8 reset outputs", {busy8, done8, gt8, eq8, lt8}, 0);
    check("w2 reset outputs", {busy2, done2, gt2, eq2, lt2}, 0);
    check("w16 reset outputs", {busy16, done16, gt16, eq16, lt16}, 0);
    rst8  = 1'b0;
    rst2  = 1'b0;
    rst16 = 1'b0;
    step(1);
    fork
      directed8();
      run2(1000);
      run16(1000);
    join
    step(4);
    check("w8 scoreboard drained", q8.size(), 0);
    check("w2 scoreboard drained", q2.size(), 0);
    check("w16 scoreboard drained", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
